// File: rtl/i2c_target_regif.sv
// I2C write-target feeding single-cycle strobes into the config register bank.
// Optional read path (addr+R, shifting reg_rdata out) is enabled by defining I2C_READ_EN.
module i2c_target_regif #(
  parameter logic [6:0] I2C_ADDR    = 7'h70,
  parameter int         NUM_REGS    = 32,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       reg_we,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  // Pad synchronisers; idle bus level is high, so they reset to 1 (SYNC_STAGES >= 2).
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = r_scl_d & w_scl & r_sda_d & ~w_sda;
  assign w_stop     = r_scl_d & w_scl & ~r_sda_d & w_sda;

  state_t     r_state, state_nxt;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_we_pend;
  logic       r_sda_oe;
  logic       r_busy;

  logic w_byte_full, w_addr_ok, w_sub_ok, w_reg_ok, w_read, w_in_data, w_in_ack, w_we_trig;
  logic w_oe_nxt;

  assign w_byte_full = (r_bit_cnt == 4'd8);
  assign w_sub_ok    = ({1'b0, r_shift} < NUM_REGS_W);
  assign w_reg_ok    = ({1'b0, reg_addr} < NUM_REGS_W);
  assign w_in_data   = (r_state == ADDR) || (r_state == SUB) || (r_state == WDATA) ||
                       (r_state == RDATA);
  assign w_in_ack    = (r_state == ADDR_ACK) || (r_state == SUB_ACK) ||
                       (r_state == WDATA_ACK) || (r_state == RDATA_ACK);
  assign w_we_trig   = (r_state == WDATA) && w_scl_rise && (r_bit_cnt == 4'd7) && w_reg_ok;

`ifdef I2C_READ_EN
  logic       r_rw;
  logic       r_host_ack;
  logic [7:0] r_tx, w_tx_nxt;
  assign w_addr_ok = (r_shift[7:1] == I2C_ADDR);
  assign w_read    = r_rw;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^reg_rdata;
  assign w_addr_ok      = (r_shift[7:1] == I2C_ADDR) && !r_shift[0];
  assign w_read         = 1'b0;
`endif

  // Decisions are taken on the SCL falling edge that ends the 8th bit, so the
  // ACK/NAK level is in place for the whole 9th clock.
  always_comb begin
    state_nxt = r_state;
    if (w_start) begin
      state_nxt = ADDR;
    end else if (w_stop) begin
      state_nxt = IDLE;
    end else if (w_scl_fall) begin
      case (r_state)
        ADDR:      if (w_byte_full) state_nxt = w_addr_ok ? ADDR_ACK : IGNORE;
        SUB:       if (w_byte_full) state_nxt = w_sub_ok ? SUB_ACK : IGNORE;
        WDATA:     if (w_byte_full) state_nxt = w_reg_ok ? WDATA_ACK : IGNORE;
        ADDR_ACK:  state_nxt = w_read ? RDATA : SUB;
        SUB_ACK:   state_nxt = WDATA;
        WDATA_ACK: state_nxt = WDATA;
`ifdef I2C_READ_EN
        RDATA:     if (w_byte_full) state_nxt = RDATA_ACK;
        RDATA_ACK: state_nxt = r_host_ack ? RDATA : IGNORE;
`endif
        default:   ;
      endcase
    end
  end

`ifdef I2C_READ_EN
  always_comb begin
    w_tx_nxt = r_tx;
    if ((state_nxt == RDATA) && (r_state != RDATA)) w_tx_nxt = reg_rdata;
    else if ((r_state == RDATA) && w_scl_fall)     w_tx_nxt = {r_tx[6:0], 1'b0};
  end
`endif

  always_comb begin
    w_oe_nxt = 1'b0;
    case (state_nxt)
      ADDR_ACK, SUB_ACK, WDATA_ACK: w_oe_nxt = 1'b1;
`ifdef I2C_READ_EN
      RDATA:                        w_oe_nxt = ~w_tx_nxt[7];
`endif
      default:                      w_oe_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'd0;
      r_we_pend <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= 8'd0;
      reg_wdata <= 8'd0;
    end else begin
      r_state   <= state_nxt;
      r_sda_oe  <= w_oe_nxt;
      r_busy    <= (state_nxt != IDLE) && (state_nxt != IGNORE);
      r_we_pend <= w_we_trig;
      reg_we    <= r_we_pend;
      if (r_we_pend) reg_wdata <= r_shift;

      if (w_start || (w_scl_fall && w_in_ack)) begin
        r_bit_cnt <= 4'd0;
      end else if (w_scl_rise && w_in_data && !w_byte_full) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
        r_shift   <= {r_shift[6:0], w_sda};
      end

      if ((r_state == SUB) && w_scl_fall && w_byte_full) reg_addr <= r_shift;
      else if ((r_state == WDATA_ACK) && w_scl_fall)     reg_addr <= reg_addr + 8'd1;
`ifdef I2C_READ_EN
      else if ((r_state == RDATA) && w_scl_fall && w_byte_full) reg_addr <= reg_addr + 8'd1;
`endif
    end
  end

`ifdef I2C_READ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw       <= 1'b0;
      r_host_ack <= 1'b0;
      r_tx       <= 8'd0;
    end else begin
      r_tx <= w_tx_nxt;
      if ((r_state == ADDR) && w_scl_fall && w_byte_full) r_rw <= r_shift[0];
      if ((r_state == RDATA_ACK) && w_scl_rise)          r_host_ack <= ~w_sda;
    end
  end
`endif

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_i2c_target_regif.sv
// Directed + randomized bench for i2c_target_regif: a bit-level host drives frames,
// a frame-level model predicts ACKs and register writes.
`timescale 1ns/1ps
module tb_i2c_target_regif;

  localparam int Q        = 6;   // clk cycles per quarter SCL period
  localparam int NUM_REGS = 32;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_scl = 1'b1;
  logic       host_sda = 1'b1;
  logic       scl_i, sda_i;
  logic       sda_oe, reg_we, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'hC3;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  // Open-drain wired-AND of host and target.
  assign scl_i = host_scl;
  assign sda_i = host_sda & ~sda_oe;

  i2c_target_regif dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  bit          exp_ack_q[$];
  logic [7:0]  tx_q[$];
  int          got_rd = 0;
  int          oe_cnt = 0;
  int          we_long = 0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (reg_we) got_q.push_back({reg_addr, reg_wdata});
    if (reg_we && prev_we) we_long++;
    prev_we <= reg_we;
    if (sda_oe) oe_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- host driver tasks ----------------
  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    host_sda = 1'b1; wq();
    host_scl = 1'b1; wq();
    host_sda = 1'b0; wq();
    host_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    host_sda = 1'b0; wq();
    host_scl = 1'b1; wq();
    host_sda = 1'b1; wq();
  endtask

  task automatic send_bit(input logic b);
    host_sda = b; wq();
    host_scl = 1'b1; wq(); wq();
    host_scl = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    host_sda = 1'b1; wq();
    host_scl = 1'b1; wq();
    ack = (sda_i == 1'b0);
    wq();
    host_scl = 1'b0; wq();
  endtask

  task automatic read_byte(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      host_sda = 1'b1; wq();
      host_scl = 1'b1; wq();
      b[i] = sda_i;
      wq();
      host_scl = 1'b0; wq();
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level rules: address must be ours with W; sub-address must exist;
  // each data byte is written to the running pointer while it is in range.
  task automatic model_frame();
    logic [7:0] ptr;
    bit         live;
    ptr = 8'd0;
    exp_ack_q.delete();
    live = (tx_q[0][7:1] == 7'h70) && (tx_q[0][0] == 1'b0);
    exp_ack_q.push_back(live);
    for (int i = 1; i < tx_q.size(); i++) begin
      if (live && i == 1) begin
        ptr  = tx_q[1];
        live = (int'(ptr) < NUM_REGS);
      end else if (live) begin
        live = (int'(ptr) < NUM_REGS);
        if (live) begin
          exp_q.push_back({ptr, tx_q[i]});
          ptr = ptr + 8'd1;
        end
      end
      exp_ack_q.push_back(live);
    end
  endtask

  task automatic run_frame(input string tag, input bit do_stop);
    bit a;
    model_frame();
    i2c_start();
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i], a);
      chk({tag, " ack"}, 32'(a), 32'(exp_ack_q[i]));
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic check_writes(input string tag);
    int n_got;
    repeat (4) @(posedge clk);
    #1;
    n_got = got_q.size() - got_rd;
    chk({tag, " strobes"}, 32'(n_got), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      if (got_rd < got_q.size()) begin
        chk({tag, " wr"}, 32'(got_q[got_rd]), 32'(e));
        got_rd++;
      end
    end
    got_rd = got_q.size();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          a;
    int          oe_before;
    logic [7:0]  sb;
    logic [7:0]  rb;
    logic [31:0] tmp;

    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset sda_oe", 32'(sda_oe), 32'd0);
    chk("reset reg_we", 32'(reg_we), 32'd0);
    chk("reset reg_addr", 32'(reg_addr), 32'd0);
    chk("reset reg_wdata", 32'(reg_wdata), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wq();

    // Two-byte write with auto-increment; busy across the frame.
    tx_q = '{8'hE0, 8'h0A, 8'h55, 8'h1F};
    run_frame("t1", 1'b0);
    chk("t1 busy mid", 32'(busy), 32'd1);
    i2c_stop();
    wq();
    chk("t1 busy end", 32'(busy), 32'd0);
    check_writes("t1");

    // Wrong address: never drive SDA.
    oe_before = oe_cnt;
    tx_q = '{8'hE2, 8'h0A, 8'h12};
    run_frame("t2", 1'b1);
    chk("t2 oe cycles", 32'(oe_cnt - oe_before), 32'd0);
    check_writes("t2");

    // Last register written, next byte out of range.
    tx_q = '{8'hE0, 8'h1F, 8'hAA, 8'hBB};
    run_frame("t3", 1'b1);
    check_writes("t3");

    // Sub-address out of range.
    tx_q = '{8'hE0, 8'h20, 8'h11};
    run_frame("t3b", 1'b1);
    check_writes("t3b");

    // STOP mid-byte discards the partial byte.
    tx_q = '{8'hE0, 8'h05};
    run_frame("t4a", 1'b0);
    sb = 8'hF5;
    for (int i = 7; i >= 3; i--) send_bit(sb[i]);
    i2c_stop();
    check_writes("t4a");
    tx_q = '{8'hE0, 8'h03, 8'h07};
    run_frame("t4b", 1'b1);
    check_writes("t4b");

    // Reset while ACKing the sub-address.
    i2c_start();
    send_byte(8'hE0, a);
    chk("t5 addr ack", 32'(a), 32'd1);
    sb = 8'h05;
    for (int i = 7; i >= 0; i--) send_bit(sb[i]);
    host_sda = 1'b1;
    chk("t5 ack driven", 32'(sda_oe), 32'd1);
    chk("t5 busy before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5 async sda_oe", 32'(sda_oe), 32'd0);
    chk("t5 async busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wq();
    i2c_stop();
    tx_q = '{8'hE0, 8'h04, 8'h99};
    run_frame("t5", 1'b1);
    check_writes("t5");

`ifdef I2C_READ_EN
    // Write sub-address, repeated START, read one byte then NAK.
    tx_q = '{8'hE0, 8'h02};
    run_frame("t6", 1'b0);
    check_writes("t6 sub");
    reg_rdata = 8'hC3;
    i2c_start();
    send_byte(8'hE1, a);
    chk("t6 read ack", 32'(a), 32'd1);
    read_byte(rb);
    chk("t6 read data", 32'(rb), 32'hC3);
    chk("t6 addr incr", 32'(reg_addr), 32'h03);
    send_bit(1'b1);
    oe_before = oe_cnt;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    chk("t6 ignore oe", 32'(oe_cnt - oe_before), 32'd0);
    i2c_stop();
    wq();
    chk("t6 busy end", 32'(busy), 32'd0);
`else
    // Read request is refused when reads are not built in.
    tx_q = '{8'hE1, 8'h0A};
    run_frame("t6 rd nak", 1'b1);
    check_writes("t6 rd nak");
`endif

    // Randomized write frames.
    for (int f = 0; f < 20; f++) begin
      int n;
      tx_q.delete();
      if ($urandom_range(0, 9) == 0) begin
        tmp = $urandom_range(0, 127);
        tx_q.push_back({tmp[6:0], 1'b0});
      end else begin
        tx_q.push_back(8'hE0);
      end
      tmp = $urandom_range(0, 40);
      tx_q.push_back(tmp[7:0]);
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        tmp = $urandom;
        tx_q.push_back(tmp[7:0]);
      end
      run_frame("rand", 1'b1);
      check_writes("rand");
    end

    chk("we width", 32'(we_long), 32'd0);
    chk("final busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
